// File: rtl/keypad_scanner.sv
// Column-scanning 4x3 keypad front end with whole-matrix debounce and one-hot digit decode.
// Define KEYPAD_REPEAT_EN to add key_strobe auto-repeat while a single key stays held.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [9:0] keypad,
  output logic       star,
  output logic       hash,
  output logic       key_strobe
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_FULL    = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  if (SETTLE_CYCLES < 3 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
    $error("keypad_scanner: illegal parameter value");
  end

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2
  } col_state_t;

  col_state_t      state_reg, state_next;
  logic [SW-1:0]   settle_reg, settle_next;
  logic [2:0]      col_n_reg, col_n_next;
  logic            window_end;
  logic            scan_done;

  logic [3:0]      row_meta_reg, row_sync_reg;
  logic [11:0]     snap_reg, snap_next;
  logic [11:0]     cand_reg, cand_next;
  logic [11:0]     acc_reg, acc_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            acc_change;
  logic            repeat_fire;
  logic            strobe_req_reg, strobe_req_next;

  logic [9:0]      key_dec;
  logic            acc_single;
  logic [9:0]      keypad_reg;
  logic            star_reg, hash_reg, key_strobe_reg;

  // Column scan: each column window lasts SETTLE_CYCLES, rows sampled on its last cycle.
  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg + SW'(1);
    window_end  = (settle_reg == SETTLE_LAST);
    if (window_end) begin
      settle_next = '0;
      case (state_reg)
        COL0:    state_next = COL1;
        COL1:    state_next = COL2;
        default: state_next = COL0;
      endcase
    end
    case (state_next)
      COL0:    col_n_next = 3'b110;
      COL1:    col_n_next = 3'b101;
      default: col_n_next = 3'b011;
    endcase
  end

  assign scan_done = window_end && (state_reg == COL2);

  // Snapshot bit index is row*3 + column; a set bit means the key is down.
  always_comb begin
    snap_next = snap_reg;
    if (window_end) begin
      for (int r = 0; r < 4; r++) begin
        snap_next[r*3 + int'(state_reg)] = ~row_sync_reg[r];
      end
    end
  end

  // Debounce on complete snapshots; acceptance can happen on the same scan that fills the count.
  always_comb begin
    cand_next  = cand_reg;
    count_next = count_reg;
    acc_next   = acc_reg;
    if (scan_done) begin
      if (snap_next != cand_reg) begin
        cand_next  = snap_next;
        count_next = CNT_ONE;
      end else if (count_reg != DEB_FULL) begin
        count_next = count_reg + CNT_ONE;
      end
      if (count_next == DEB_FULL && cand_next != acc_reg) begin
        acc_next = cand_next;
      end
    end
  end

  assign acc_change      = (acc_next != acc_reg);
  assign strobe_req_next = (acc_change && $onehot(acc_next)) || repeat_fire;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);

  logic [RW-1:0] rep_cnt_reg, rep_cnt_next;

  always_comb begin
    rep_cnt_next = rep_cnt_reg;
    repeat_fire  = 1'b0;
    if (acc_change) begin
      rep_cnt_next = '0;
    end else if (scan_done && $onehot(acc_reg)) begin
      if (rep_cnt_reg == REP_LAST) begin
        rep_cnt_next = '0;
        repeat_fire  = 1'b1;
      end else begin
        rep_cnt_next = rep_cnt_reg + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_reg <= '0;
    end else begin
      rep_cnt_reg <= rep_cnt_next;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  // Matrix position to digit: rows 0-2 hold 1..9 in order, row 3 column 1 is digit 0.
  assign key_dec[0] = acc_reg[10];
  for (genvar gi = 1; gi < 10; gi++) begin : g_digit
    assign key_dec[gi] = acc_reg[gi-1];
  end
  assign acc_single = $onehot(acc_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= COL0;
      settle_reg     <= '0;
      col_n_reg      <= 3'b110;
      row_meta_reg   <= 4'hF;
      row_sync_reg   <= 4'hF;
      snap_reg       <= '0;
      cand_reg       <= '0;
      acc_reg        <= '0;
      count_reg      <= '0;
      strobe_req_reg <= 1'b0;
      keypad_reg     <= '0;
      star_reg       <= 1'b0;
      hash_reg       <= 1'b0;
      key_strobe_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      settle_reg     <= settle_next;
      col_n_reg      <= col_n_next;
      row_meta_reg   <= row_n;
      row_sync_reg   <= row_meta_reg;
      snap_reg       <= snap_next;
      cand_reg       <= cand_next;
      acc_reg        <= acc_next;
      count_reg      <= count_next;
      strobe_req_reg <= strobe_req_next;
      // Outputs trail acceptance by one cycle so the strobe lines up with the new levels.
      keypad_reg     <= acc_single ? key_dec : 10'd0;
      star_reg       <= acc_single & acc_reg[9];
      hash_reg       <= acc_single & acc_reg[11];
      key_strobe_reg <= strobe_req_reg;
    end
  end

  assign col_n      = col_n_reg;
  assign keypad     = keypad_reg;
  assign star       = star_reg;
  assign hash       = hash_reg;
  assign key_strobe = key_strobe_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus pushes expected output events with their
// cycle of appearance; a negedge monitor pops and compares whenever outputs change or strobe.
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int REP    = 8;
  localparam int T      = 3 * SETTLE;
  localparam int LAT    = DEB * T + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [9:0]  keypad;
  logic        star, hash, key_strobe;

  logic [11:0] pressed = '0;
  logic [11:0] prev_out = '0;
  int          cyc = 0;
  int          base = 0;
  int          checks = 0;
  int          failures = 0;
  int          col_bad = 0;
  bit          mon_en = 1'b0;

  typedef struct {
    int         at;
    logic [9:0] kp;
    logic       st;
    logic       hs;
    logic       sb;
    int         tag;
  } exp_t;

  exp_t exp_q[$];

  keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (REP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .keypad    (keypad),
    .star      (star),
    .hash      (hash),
    .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3 + c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic expect_evt(input int at, input logic [9:0] kp, input logic st,
                            input logic hs, input logic sb, input int tag);
    exp_t e;
    e.at = at; e.kp = kp; e.st = st; e.hs = hs; e.sb = sb; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic goto_scan(input int k);
    while (cyc < base + T * k) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (col_n != 3'b110 && col_n != 3'b101 && col_n != 3'b011) col_bad++;
      if ({keypad, star, hash} !== prev_out[11:0] || key_strobe !== 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: cyc=%0d keypad=%b star=%b hash=%b strobe=%b",
                   cyc, keypad, star, hash, key_strobe);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cyc != e.at || keypad !== e.kp || star !== e.st || hash !== e.hs || key_strobe !== e.sb) begin
            failures++;
            $display("FAIL event%0d: got cyc=%0d keypad=%b star=%b hash=%b strobe=%b want cyc=%0d keypad=%b star=%b hash=%b strobe=%b",
                     e.tag, cyc, keypad, star, hash, key_strobe, e.at, e.kp, e.st, e.hs, e.sb);
          end else begin
            $display("event%0d ok: cyc=%0d keypad=%b star=%b hash=%b strobe=%b",
                     e.tag, cyc, keypad, star, hash, key_strobe);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].at < cyc) begin
        checks++;
        failures++;
        $display("FAIL event%0d_missing: got no event by cyc=%0d want cyc=%0d",
                 exp_q[0].tag, cyc, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      prev_out[11:0] = {keypad, star, hash};
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {19'd0, keypad, star, hash, key_strobe}, 32'd0);
    check("reset_col_n", {29'd0, col_n}, 32'b110);

    // Key 5 held through reset release, then released.
    pressed  = 12'h010;
    prev_out = '0;
    rst      = 1'b0;
    base     = cyc;
    mon_en   = 1'b1;
    expect_evt(base + LAT, 10'b0000100000, 1'b0, 1'b0, 1'b1, 1);
    goto_scan(5);
    pressed = '0;
    expect_evt(base + 5*T + LAT, 10'd0, 1'b0, 1'b0, 1'b0, 2);

    // Key 0 bouncing every scan is never accepted, then accepted once steady.
    for (int k = 8; k < 18; k++) begin
      goto_scan(k);
      pressed = (k % 2 == 0) ? 12'h400 : 12'h000;
    end
    goto_scan(18);
    pressed = 12'h400;
    expect_evt(base + 18*T + LAT, 10'b0000000001, 1'b0, 1'b0, 1'b1, 3);
    goto_scan(23);
    pressed = '0;
    expect_evt(base + 23*T + LAT, 10'd0, 1'b0, 1'b0, 1'b0, 4);

    // Keys 1+2 together are rejected; dropping 2 leaves a valid single key 1.
    goto_scan(26);
    pressed = 12'h003;
    goto_scan(31);
    pressed = 12'h001;
    expect_evt(base + 31*T + LAT, 10'b0000000010, 1'b0, 1'b0, 1'b1, 5);
    goto_scan(36);
    pressed = '0;
    expect_evt(base + 36*T + LAT, 10'd0, 1'b0, 1'b0, 1'b0, 6);

    // Hash, then a one-cycle reset while still held.
    goto_scan(39);
    pressed = 12'h800;
    expect_evt(base + 39*T + LAT, 10'd0, 1'b0, 1'b1, 1'b1, 7);
    goto_scan(44);
    rst = 1'b1;
    expect_evt(cyc + 1, 10'd0, 1'b0, 1'b0, 1'b0, 8);
    @(negedge clk);
    check("midreset_col_n", {29'd0, col_n}, 32'b110);
    check("midreset_strobe", {31'd0, key_strobe}, 32'd0);
    rst  = 1'b0;
    base = cyc;
    expect_evt(base + LAT, 10'd0, 1'b0, 1'b1, 1'b1, 9);

    // Switch directly from hash to 9: a single-to-single change strobes again.
    goto_scan(5);
    pressed = 12'h100;
    expect_evt(base + 5*T + LAT, 10'b1000000000, 1'b0, 1'b0, 1'b1, 10);
`ifdef KEYPAD_REPEAT_EN
    for (int i = 1; i <= 3; i++)
      expect_evt(base + 5*T + LAT + i*REP*T, 10'b1000000000, 1'b0, 1'b0, 1'b1, 10 + i);
`endif
    goto_scan(35);
    pressed = '0;
    expect_evt(base + 35*T + LAT, 10'd0, 1'b0, 1'b0, 1'b0, 14);
    goto_scan(40);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("col_n_one_low", col_bad, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
